// File: rtl/sprite_starfield_unit.sv
// Sprite line renderer with a scaled, DMA-fed line buffer, plus an
// LFSR-based starfield generator that shares the same pixel clock.
module sprite_starfield_unit #(
  parameter int          WIDTH   = 8,
  parameter int          HEIGHT  = 8,
  parameter int          SCALE_X = 8,
  parameter int          SCALE_Y = 8,
  parameter int          LSB     = 0,
  parameter int          CORDW   = 16,
  parameter int          ADDRW   = 3,
  parameter int          H       = 800,
  parameter int          V       = 525,
  parameter int          INC     = -1,
  parameter logic [20:0] SEED    = 21'h1FFFFF,
  parameter logic [20:0] MASK    = 21'hFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    dma_avail,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sprx,
  input  logic        [WIDTH-1:0] data_in,
  output logic        [ADDRW-1:0] pos,
  output logic                    pix,
  output logic                    drawing,
  output logic                    done,
  input  logic                    sf_en,
  output logic                    sf_on,
  output logic              [7:0] sf_star
);

  localparam int CntXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int BitW  = (WIDTH > 1)   ? $clog2(WIDTH)   : 1;
  localparam int CntYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  localparam logic [CntXW-1:0] CntXLast = CntXW'(SCALE_X - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);
  localparam logic [CntYW-1:0] CntYLast = CntYW'(SCALE_Y - 1);
  localparam logic [ADDRW-1:0] PosLast  = ADDRW'(HEIGHT - 1);

  localparam int          RstCntInt = H * V + INC - 1;
  localparam logic [20:0] RstCnt    = 21'(RstCntInt);
  localparam logic [20:0] Taps      = 21'h140000;

  typedef enum logic [2:0] {
    StIdle,
    StWaitDma,
    StLatch,
    StWaitPos,
    StDraw,
    StLineEnd,
    StDone
  } state_e;

  // Sprite state
  state_e             r_state;
  logic [ADDRW-1:0]   r_pos;
  logic [CntXW-1:0]   r_cnt_x;
  logic [BitW-1:0]    r_bit;
  logic [CntYW-1:0]   r_cnt_y;
  logic [WIDTH-1:0]   r_buf;

  state_e             w_state_nxt;
  logic [ADDRW-1:0]   w_pos_nxt;
  logic [CntXW-1:0]   w_cnt_x_nxt;
  logic [BitW-1:0]    w_bit_nxt;
  logic [CntYW-1:0]   w_cnt_y_nxt;
  logic [WIDTH-1:0]   w_buf_nxt;

  logic signed [CORDW-1:0] w_sprx_m1;
  logic [BitW-1:0]         w_bit_sel;

  // Starfield state
  logic [20:0] r_sf_cnt;
  logic [20:0] r_sreg;
  logic [20:0] w_sf_cnt_nxt;
  logic [20:0] w_sreg_nxt;
  logic [20:0] w_sreg_shift;

  // Entering DRAW one pixel early lines the first drawn pixel up with sx == sprx.
  assign w_sprx_m1 = sprx - CORDW'(1);

  // Sprite state register with synchronous reset; reset aborts any draw in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pos   <= '0;
      r_cnt_x <= '0;
      r_bit   <= '0;
      r_cnt_y <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_cnt_x <= w_cnt_x_nxt;
      r_bit   <= w_bit_nxt;
      r_cnt_y <= w_cnt_y_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // Sprite next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_cnt_x_nxt = r_cnt_x;
    w_bit_nxt   = r_bit;
    w_cnt_y_nxt = r_cnt_y;
    w_buf_nxt   = r_buf;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_pos_nxt   = '0;
          w_cnt_y_nxt = '0;
          w_state_nxt = StWaitDma;
        end
      end
      StWaitDma: begin
        if (dma_avail) w_state_nxt = StLatch;
      end
      StLatch: begin
        // ROM data arrives the cycle after the granted slot.
        w_buf_nxt   = data_in;
        w_state_nxt = StWaitPos;
      end
      StWaitPos: begin
        if (sx == w_sprx_m1) begin
          w_bit_nxt   = '0;
          w_cnt_x_nxt = '0;
          w_state_nxt = StDraw;
        end
      end
      StDraw: begin
        if (r_cnt_x == CntXLast) begin
          w_cnt_x_nxt = '0;
          if (r_bit == BitLast) begin
            w_state_nxt = StLineEnd;
          end else begin
            w_bit_nxt = r_bit + BitW'(1);
          end
        end else begin
          w_cnt_x_nxt = r_cnt_x + CntXW'(1);
        end
      end
      StLineEnd: begin
        if (r_cnt_y < CntYLast) begin
          w_cnt_y_nxt = r_cnt_y + CntYW'(1);
          w_state_nxt = StWaitDma;
        end else begin
          w_cnt_y_nxt = '0;
          if (r_pos == PosLast) begin
            w_state_nxt = StDone;
          end else begin
            w_pos_nxt   = r_pos + ADDRW'(1);
            w_state_nxt = StWaitDma;
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Sprite outputs decoded from registered state only.
  always_comb begin
    w_bit_sel = r_bit;
    if (LSB == 0) w_bit_sel = BitLast - r_bit;
    pos     = r_pos;
    drawing = (r_state == StDraw);
    done    = (r_state == StDone);
    pix     = drawing & r_buf[w_bit_sel];
  end

  // Starfield counter and LFSR registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sf_cnt <= '0;
      r_sreg   <= SEED;
    end else begin
      r_sf_cnt <= w_sf_cnt_nxt;
      r_sreg   <= w_sreg_nxt;
    end
  end

  // Starfield next state; the reload at count zero applies even when not enabled.
  always_comb begin
    w_sreg_shift = {1'b0, r_sreg[20:1]} ^ (r_sreg[0] ? Taps : 21'h0);
    w_sf_cnt_nxt = r_sf_cnt;
    w_sreg_nxt   = r_sreg;
    if (sf_en) begin
      w_sf_cnt_nxt = (r_sf_cnt == RstCnt) ? 21'h0 : r_sf_cnt + 21'h1;
      w_sreg_nxt   = w_sreg_shift;
    end
    if (r_sf_cnt == 21'h0) w_sreg_nxt = SEED;
  end

  // Star outputs straight from the LFSR.
  always_comb begin
    sf_on   = &(r_sreg | MASK);
    sf_star = r_sreg[7:0];
  end

endmodule

// File: tb/tb_sprite_starfield_unit.sv
module tb_sprite_starfield_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b0;
  logic               start_a = 1'b0;
  logic               start_b = 1'b0;
  logic               dma_avail = 1'b0;
  logic               sf_en = 1'b0;
  logic signed [15:0] sx = 16'sd0;
  logic signed [15:0] sprx = 16'sd64;
  logic [7:0]         data_a = 8'h00;
  logic [7:0]         data_b = 8'h00;

  logic [2:0] pos_a, pos_b, pos_c;
  logic       pix_a, pix_b, pix_c;
  logic       drawing_a, drawing_b, drawing_c;
  logic       done_a, done_b, done_c;
  logic       sf_on_a, sf_on_b, sf_on_c;
  logic [7:0] sf_star_a, sf_star_b, sf_star_c;

  // Defaults (LSB=0), full-size starfield.
  sprite_starfield_unit dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dma_avail(dma_avail),
    .sx(sx), .sprx(sprx), .data_in(data_a), .pos(pos_a), .pix(pix_a),
    .drawing(drawing_a), .done(done_a), .sf_en(sf_en), .sf_on(sf_on_a),
    .sf_star(sf_star_a)
  );

  // LSB=1, two lines tall, no vertical repeat.
  sprite_starfield_unit #(.LSB(1), .HEIGHT(2), .SCALE_Y(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dma_avail(dma_avail),
    .sx(sx), .sprx(sprx), .data_in(data_b), .pos(pos_b), .pix(pix_b),
    .drawing(drawing_b), .done(done_b), .sf_en(sf_en), .sf_on(sf_on_b),
    .sf_star(sf_star_b)
  );

  // Tiny starfield: period of 7 enabled cycles.
  sprite_starfield_unit #(.H(4), .V(2), .INC(-1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(1'b0), .dma_avail(1'b0),
    .sx(sx), .sprx(sprx), .data_in(8'h00), .pos(pos_c), .pix(pix_c),
    .drawing(drawing_c), .done(done_c), .sf_en(sf_en), .sf_on(sf_on_c),
    .sf_star(sf_star_c)
  );

  typedef struct {
    int         sx;
    logic       pix;
    logic [2:0] pos;
  } pix_exp_t;

  typedef struct {
    logic       on;
    logic [7:0] star;
  } sf_exp_t;

  pix_exp_t q_a[$];
  pix_exp_t q_b[$];
  int       q_done_a[$];
  int       q_done_b[$];
  sf_exp_t  q_sfa[$];
  sf_exp_t  q_sfc[$];

  int   n_cmp = 0;
  int   n_fail = 0;
  int   spans_a = 0;
  int   spans_b = 0;
  logic prev_draw_a = 1'b0;
  logic prev_draw_b = 1'b0;
  logic mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: DUT output present but no expected entry queued (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [7:0] d, input bit lsb1, input logic [2:0] p,
                           input bit to_b, input int n);
    pix_exp_t   e;
    logic [7:0] dv;
    dv = d;
    for (int i = 0; i < n; i++) begin
      e.sx  = 64 + i;
      e.pos = p;
      e.pix = lsb1 ? dv[i / 8] : dv[7 - i / 8];
      if (to_b) q_b.push_back(e);
      else q_a.push_back(e);
    end
  endtask

  task automatic push_sf(input bit to_c, input logic on, input logic [7:0] star);
    sf_exp_t e;
    e.on   = on;
    e.star = star;
    if (to_c) q_sfc.push_back(e);
    else q_sfa.push_back(e);
  endtask

  // One scanline: optional start, DMA grant in h-blank, data the next cycle, then an sx sweep.
  task automatic do_line(input logic [7:0] da, input logic [7:0] db, input bit sa, input bit sb,
                         input bit noise);
    tick(); sx = 16'sd0; start_a = sa; start_b = sb;
    tick(); start_a = noise; start_b = 1'b0; dma_avail = 1'b1;
    tick(); start_a = 1'b0; dma_avail = 1'b0; data_a = da; data_b = db;
    tick(); data_a = ~da; data_b = ~db; sx = 16'sd60;
    for (int x = 61; x <= 131; x++) begin
      tick();
      sx = 16'(x);
      start_a = noise && (x == 100);
    end
  endtask

  // Monitor for dut_a sprite plus both starfields.
  always @(negedge clk) begin
    pix_exp_t e;
    sf_exp_t  s;
    if (mon_on) begin
      if (drawing_a) begin
        if (q_a.size() == 0) miss("a_draw");
        else begin
          e = q_a.pop_front();
          check("a_sx", 32'(sx), 32'(e.sx));
          check("a_pix", 32'(pix_a), 32'(e.pix));
          check("a_pos", 32'(pos_a), 32'(e.pos));
        end
      end else if (prev_draw_a) spans_a++;
      prev_draw_a = drawing_a;
      if (done_a) begin
        if (q_done_a.size() == 0) miss("a_done");
        else check("a_done_spans", 32'(spans_a), 32'(q_done_a.pop_front()));
      end
      if (sf_en) begin
        if (q_sfa.size() == 0) miss("a_sf");
        else begin
          s = q_sfa.pop_front();
          check("a_sf_on", 32'(sf_on_a), 32'(s.on));
          check("a_sf_star", 32'(sf_star_a), 32'(s.star));
        end
        if (q_sfc.size() == 0) miss("c_sf");
        else begin
          s = q_sfc.pop_front();
          check("c_sf_on", 32'(sf_on_c), 32'(s.on));
          check("c_sf_star", 32'(sf_star_c), 32'(s.star));
        end
      end
    end
  end

  // Monitor for dut_b sprite.
  always @(negedge clk) begin
    pix_exp_t e;
    if (mon_on) begin
      if (drawing_b) begin
        if (q_b.size() == 0) miss("b_draw");
        else begin
          e = q_b.pop_front();
          check("b_sx", 32'(sx), 32'(e.sx));
          check("b_pix", 32'(pix_b), 32'(e.pix));
          check("b_pos", 32'(pos_b), 32'(e.pos));
        end
      end else if (prev_draw_b) spans_b++;
      prev_draw_b = drawing_b;
      if (done_b) begin
        if (q_done_b.size() == 0) miss("b_done");
        else check("b_done_spans", 32'(spans_b), 32'(q_done_b.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat [8];
    logic [7:0] star_a [21];
    logic [7:0] dbv;
    pat = '{8'h81, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h55, 8'hFF, 8'h00};
    // Hand-stepped LFSR low bytes from SEED; sf_on is 1 only for the first two observations.
    star_a = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01,
               8'h00};
    for (int k = 0; k < 21; k++) begin
      push_sf(1'b0, (k < 2), star_a[k]);
      // Period-7 field: SEED is seen at observations 0, 1, 8, 15.
      push_sf(1'b1, (k == 0) || (k == 1) || (k == 8) || (k == 15), 8'hFF);
    end

    // Reset state.
    tick(); tick();
    @(negedge clk);
    check("rst_pix", 32'(pix_a), 32'd0);
    check("rst_drawing", 32'(drawing_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_sf_on", 32'(sf_on_a), 32'd1);
    check("rst_sf_star", 32'(sf_star_a), 32'hFF);
    check("rst_pos", 32'(pos_a), 32'd0);

    // Starfield: 5 enabled cycles, a 4-cycle hold, then 16 more.
    tick(); rst_n = 1'b1; sf_en = 1'b1; mon_on = 1'b1;
    repeat (4) tick();
    tick(); sf_en = 1'b0;
    repeat (3) tick();
    tick(); sf_en = 1'b1;
    repeat (16) tick();
    sf_en = 1'b0;
    repeat (3) tick();

    // Full sprite on dut_a; dut_b draws two lines alongside.
    for (int l = 0; l < 64; l++) begin
      push_line(pat[l % 8], 1'b0, 3'(l / 8), 1'b0, 64);
      dbv = (l == 0) ? 8'h01 : 8'h80;
      if (l < 2) push_line(dbv, 1'b1, 3'(l), 1'b1, 64);
      if (l == 63) q_done_a.push_back(64);
      if (l == 1) q_done_b.push_back(2);
      do_line(pat[l % 8], dbv, (l == 0), (l == 0), (l % 2 == 1));
    end

    // Both back in IDLE: a DMA grant and sweep must draw nothing.
    do_line(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("a_total_spans", 32'(spans_a), 32'd64);
    check("b_total_spans", 32'(spans_b), 32'd2);

    // Reset in the middle of a DRAW.
    push_line(8'hF0, 1'b0, 3'd0, 1'b0, 17);
    tick(); sx = 16'sd0; start_a = 1'b1;
    tick(); start_a = 1'b0; dma_avail = 1'b1;
    tick(); dma_avail = 1'b0; data_a = 8'hF0;
    tick(); data_a = 8'h0F; sx = 16'sd60;
    for (int x = 61; x <= 80; x++) begin
      tick();
      sx = 16'(x);
      if (x == 80) rst_n = 1'b0;
    end
    tick(); rst_n = 1'b1; sx = 16'sd81;
    @(negedge clk);
    check("abort_drawing", 32'(drawing_a), 32'd0);
    check("abort_pix", 32'(pix_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_pos", 32'(pos_a), 32'd0);
    check("abort_sf_on", 32'(sf_on_a), 32'd1);
    check("abort_sf_star", 32'(sf_star_a), 32'hFF);
    do_line(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();

    check("q_a_left", 32'(q_a.size()), 32'd0);
    check("q_b_left", 32'(q_b.size()), 32'd0);
    check("q_done_a_left", 32'(q_done_a.size()), 32'd0);
    check("q_done_b_left", 32'(q_done_b.size()), 32'd0);
    check("q_sfa_left", 32'(q_sfa.size()), 32'd0);
    check("q_sfc_left", 32'(q_sfc.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
